// File: rtl/coreboard1588_pkg.sv
// Shared definitions for the coreboard1588 ADC packer: FSM encoding and a
// constant-evaluable log2 helper used to size FIFO pointers.
package coreboard1588_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DROP
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/coreboard1588_commit_fifo.sv
// Commit-on-frame-end FIFO: writes are tentative until commit, rollback rewinds
// the write pointer, and the reader only ever sees committed words.
module coreboard1588_commit_fifo
  import coreboard1588_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 33
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    commit,
  input  logic                    rollback,
  output logic [clog2(DEPTH):0]   free,
  output logic [clog2(DEPTH):0]   free_committed,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] DEPTH_P = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      commit_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;

  assign empty          = (rd_ptr == commit_ptr);
  assign free           = DEPTH_P - (wr_ptr - rd_ptr);
  assign free_committed = DEPTH_P - (commit_ptr - rd_ptr);

  always_ff @(posedge clk) begin
    if (wr && !rollback) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // A commit in the same cycle as the final write covers that write too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
    end else if (rollback) begin
      wr_ptr <= commit_ptr;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (commit) commit_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
    end
  end

  // Registered output stage; refills in the same cycle it is drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (!rd_valid || rd_ready) begin
      if (!empty) begin
        rd_data  <= mem[rd_ptr[AW-1:0]];
        rd_valid <= 1'b1;
        rd_ptr   <= rd_ptr + 1'b1;
      end else begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/coreboard1588_adc_packer.sv
// Packs per-channel ADS868x samples into {odd, even} 32-bit AXIS words and
// releases only complete, in-order frames downstream.
module coreboard1588_adc_packer
  import coreboard1588_pkg::*;
#(
  parameter int C_CHANNELS   = 8,
  parameter int C_FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_enable,
  input  logic        ctrl_clear_status,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  input  logic [3:0]  sample_ch,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        stat_overflow,
  output logic        stat_seq_error,
  output logic [31:0] stat_frame_count
);

  localparam int AW = clog2(C_FIFO_DEPTH);
  localparam logic [AW:0] HALF    = (AW + 1)'(C_CHANNELS / 2);
  localparam logic [3:0]  LAST_CH = 4'(C_CHANNELS - 1);

  state_t      state, next_state;
  logic [3:0]  exp_ch, next_exp_ch;
  logic [15:0] low_half;
  logic [AW:0] free, free_committed, avail;
  logic        start, load_low, wr, commit, rollback;
  logic        set_ovf, set_seq, frame_inc;
  logic [32:0] rd_data;

  always_comb begin
    next_state  = state;
    next_exp_ch = exp_ch;
    start       = 1'b0;
    avail       = free;
    load_low    = 1'b0;
    wr          = 1'b0;
    commit      = 1'b0;
    rollback    = 1'b0;
    set_ovf     = 1'b0;
    set_seq     = 1'b0;
    frame_inc   = 1'b0;
    case (state)
      S_IDLE, S_DROP: begin
        if (sample_valid && sample_ch == 4'd0) start = 1'b1;
      end
      S_ACTIVE: begin
        if (sample_valid) begin
          if (sample_ch == exp_ch) begin
            load_low = !sample_ch[0];
            wr       = sample_ch[0];
            if (sample_ch == LAST_CH) begin
              commit     = 1'b1;
              frame_inc  = 1'b1;
              next_state = S_IDLE;
            end else begin
              next_exp_ch = exp_ch + 4'd1;
            end
          end else begin
            // A stray channel 0 restarts a frame against the rolled-back space.
            rollback   = 1'b1;
            set_seq    = 1'b1;
            next_state = S_IDLE;
            if (sample_ch == 4'd0) begin
              start = 1'b1;
              avail = free_committed;
            end
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
    if (start) begin
      if (!ctrl_enable) begin
        next_state = S_IDLE;
      end else if (avail >= HALF) begin
        next_state  = S_ACTIVE;
        next_exp_ch = 4'd1;
        load_low    = 1'b1;
      end else begin
        set_ovf    = 1'b1;
        next_state = S_DROP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      exp_ch   <= '0;
      low_half <= '0;
    end else begin
      state  <= next_state;
      exp_ch <= next_exp_ch;
      if (load_low) low_half <= sample_data;
    end
  end

  // Sticky flags: a new event outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_overflow    <= 1'b0;
      stat_seq_error   <= 1'b0;
      stat_frame_count <= '0;
    end else begin
      if (set_ovf) stat_overflow <= 1'b1;
      else if (ctrl_clear_status) stat_overflow <= 1'b0;
      if (set_seq) stat_seq_error <= 1'b1;
      else if (ctrl_clear_status) stat_seq_error <= 1'b0;
      if (frame_inc) stat_frame_count <= stat_frame_count + 32'd1;
    end
  end

  coreboard1588_commit_fifo #(
    .DEPTH(C_FIFO_DEPTH),
    .WIDTH(33)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .wr            (wr),
    .wr_data       ({commit, sample_data, low_half}),
    .commit        (commit),
    .rollback      (rollback),
    .free          (free),
    .free_committed(free_committed),
    .rd_data       (rd_data),
    .rd_valid      (m_axis_tvalid),
    .rd_ready      (m_axis_tready)
  );

  assign m_axis_tdata = rd_data[31:0];
  assign m_axis_tlast = rd_data[32];

endmodule

// File: tb/tb_coreboard1588_adc_packer.sv
// Directed bench for coreboard1588_adc_packer with C_CHANNELS=8, C_FIFO_DEPTH=16.
module tb_coreboard1588_adc_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_enable;
  logic        ctrl_clear_status;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic [3:0]  sample_ch;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        stat_overflow;
  logic        stat_seq_error;
  logic [31:0] stat_frame_count;

  int tests = 0;
  int fails = 0;

  logic [32:0] got_q[$];
  logic        check_stable = 1'b0;
  logic        prev_stalled = 1'b0;
  logic [32:0] prev_word = '0;
  logic        toggle_done;

  typedef struct {
    logic [3:0]  ch;
    logic [15:0] data;
    logic        has_word;
    logic [32:0] exp_word;
  } vec_t;

  vec_t vecs[8];

  coreboard1588_adc_packer #(
    .C_CHANNELS  (8),
    .C_FIFO_DEPTH(16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ctrl_enable      (ctrl_enable),
    .ctrl_clear_status(ctrl_clear_status),
    .sample_valid     (sample_valid),
    .sample_data      (sample_data),
    .sample_ch        (sample_ch),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .stat_overflow    (stat_overflow),
    .stat_seq_error   (stat_seq_error),
    .stat_frame_count (stat_frame_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Captures every accepted word and checks output hold while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stalled = 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
      if (check_stable && prev_stalled)
        checkOutput("stall_hold", {31'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                    {31'd0, 1'b1, prev_word});
      prev_stalled = m_axis_tvalid && !m_axis_tready;
      prev_word    = {m_axis_tlast, m_axis_tdata};
    end
  end

  task automatic applyStimulus(input logic [3:0] ch, input logic [15:0] data);
    sample_valid = 1'b1;
    sample_ch    = ch;
    sample_data  = data;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [15:0] base, input int nch, input logic clr0);
    for (int c = 0; c < nch; c++) begin
      ctrl_clear_status = clr0 && (c == 0);
      applyStimulus(4'(c), base + 16'(c));
    end
    ctrl_clear_status = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitWords(input int n, input int budget, input string name);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    if (got_q.size() < n) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s timeout: got %0d words, expected %0d", name, got_q.size(), n);
    end
  endtask

  function automatic logic [32:0] expWord(input logic [15:0] base, input int k);
    return {k == 3, base + 16'(2 * k + 1), base + 16'(2 * k)};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{4'd0, 16'h1000, 1'b0, 33'h0};
    vecs[1] = '{4'd1, 16'h1001, 1'b1, {1'b0, 32'h1001_1000}};
    vecs[2] = '{4'd2, 16'h1002, 1'b0, 33'h0};
    vecs[3] = '{4'd3, 16'h1003, 1'b1, {1'b0, 32'h1003_1002}};
    vecs[4] = '{4'd4, 16'h1004, 1'b0, 33'h0};
    vecs[5] = '{4'd5, 16'h1005, 1'b1, {1'b0, 32'h1005_1004}};
    vecs[6] = '{4'd6, 16'h1006, 1'b0, 33'h0};
    vecs[7] = '{4'd7, 16'h1007, 1'b1, {1'b1, 32'h1007_1006}};

    rst = 1'b1;
    ctrl_enable = 1'b1;
    ctrl_clear_status = 1'b0;
    sample_valid = 1'b0;
    sample_data = '0;
    sample_ch = '0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    checkOutput("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    checkOutput("rst_tdata", {31'd0, m_axis_tlast, m_axis_tdata}, 64'd0);
    checkOutput("rst_flags", {62'd0, stat_overflow, stat_seq_error}, 64'd0);
    checkOutput("rst_count", {32'd0, stat_frame_count}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Test 1: one clean frame at full rate.
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i].ch, vecs[i].data);
    waitWords(4, 20, "t1");
    idle(3);
    checkOutput("t1_count", 64'(got_q.size()), 64'd4);
    begin
      int w = 0;
      for (int i = 0; i < 8; i++) begin
        if (vecs[i].has_word) begin
          checkOutput($sformatf("t1_word%0d", w), {31'd0, got_q[w]}, {31'd0, vecs[i].exp_word});
          w++;
        end
      end
    end
    checkOutput("t1_frames", {32'd0, stat_frame_count}, 64'd1);
    checkOutput("t1_idle_tvalid", {63'd0, m_axis_tvalid}, 64'd0);

    // Test 2: fill the FIFO with tready low, fifth frame is dropped.
    got_q.delete();
    m_axis_tready = 1'b0;
    for (int f = 0; f < 5; f++) sendFrame(16'h2000 + 16'(f * 16'h100), 8, 1'b0);
    idle(2);
    checkOutput("t2_overflow", {63'd0, stat_overflow}, 64'd1);
    checkOutput("t2_frames", {32'd0, stat_frame_count}, 64'd5);
    checkOutput("t2_no_pop", 64'(got_q.size()), 64'd0);
    m_axis_tready = 1'b1;
    waitWords(16, 60, "t2");
    idle(3);
    checkOutput("t2_count", 64'(got_q.size()), 64'd16);
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 4; k++)
        checkOutput($sformatf("t2_f%0d_w%0d", f, k), {31'd0, got_q[f * 4 + k]},
                    {31'd0, expWord(16'h2000 + 16'(f * 16'h100), k)});
    ctrl_clear_status = 1'b1;
    idle(1);
    ctrl_clear_status = 1'b0;

    // Test 3: channel-order error aborts the frame with nothing emitted.
    got_q.delete();
    applyStimulus(4'd0, 16'h3000);
    applyStimulus(4'd1, 16'h3001);
    applyStimulus(4'd2, 16'h3002);
    applyStimulus(4'd3, 16'h3003);
    applyStimulus(4'd5, 16'h3005);
    checkOutput("t3_seq_error", {63'd0, stat_seq_error}, 64'd1);
    checkOutput("t3_overflow", {63'd0, stat_overflow}, 64'd0);
    idle(6);
    checkOutput("t3_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    checkOutput("t3_no_words", 64'(got_q.size()), 64'd0);
    sendFrame(16'h3100, 8, 1'b0);
    waitWords(4, 20, "t3");
    idle(4);
    checkOutput("t3_count", 64'(got_q.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("t3_w%0d", k), {31'd0, got_q[k]}, {31'd0, expWord(16'h3100, k)});
    checkOutput("t3_frames", {32'd0, stat_frame_count}, 64'd6);
    ctrl_clear_status = 1'b1;
    idle(1);
    ctrl_clear_status = 1'b0;
    checkOutput("t3_cleared", {63'd0, stat_seq_error}, 64'd0);

    // Test 4: tready toggling across two frames.
    got_q.delete();
    check_stable = 1'b1;
    toggle_done = 1'b0;
    fork
      begin
        sendFrame(16'h4000, 8, 1'b0);
        sendFrame(16'h4100, 8, 1'b0);
        waitWords(8, 60, "t4");
        toggle_done = 1'b1;
      end
      begin
        while (!toggle_done) begin
          m_axis_tready = ~m_axis_tready;
          @(posedge clk);
          #1;
        end
      end
    join
    m_axis_tready = 1'b1;
    idle(4);
    check_stable = 1'b0;
    checkOutput("t4_count", 64'(got_q.size()), 64'd8);
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 4; k++)
        checkOutput($sformatf("t4_f%0d_w%0d", f, k), {31'd0, got_q[f * 4 + k]},
                    {31'd0, expWord(16'h4000 + 16'(f * 16'h100), k)});

    // Test 5: reset mid-frame with committed words still buffered.
    m_axis_tready = 1'b0;
    sendFrame(16'h5000, 8, 1'b0);
    begin
      int c = 0;
      while (!m_axis_tvalid && c < 10) begin
        @(posedge clk);
        c++;
      end
      #1;
    end
    checkOutput("t5_pre_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    m_axis_tready = 1'b1;
    idle(1);
    m_axis_tready = 1'b0;
    sendFrame(16'h5100, 3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    checkOutput("t5_rst_count", {32'd0, stat_frame_count}, 64'd0);
    idle(2);
    got_q.delete();
    rst = 1'b0;
    m_axis_tready = 1'b1;
    idle(1);
    sendFrame(16'h5200, 8, 1'b0);
    waitWords(4, 20, "t5");
    idle(4);
    checkOutput("t5_count", 64'(got_q.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("t5_w%0d", k), {31'd0, got_q[k]}, {31'd0, expWord(16'h5200, k)});
    checkOutput("t5_frames", {32'd0, stat_frame_count}, 64'd1);

    // Test 6: drop coincident with clear, clear alone, enable gating.
    got_q.delete();
    m_axis_tready = 1'b0;
    for (int f = 0; f < 4; f++) sendFrame(16'h6000 + 16'(f * 16'h100), 8, 1'b0);
    sendFrame(16'h6400, 8, 1'b1);
    checkOutput("t6_set_wins", {63'd0, stat_overflow}, 64'd1);
    ctrl_clear_status = 1'b1;
    idle(1);
    ctrl_clear_status = 1'b0;
    checkOutput("t6_clear", {63'd0, stat_overflow}, 64'd0);
    checkOutput("t6_frames", {32'd0, stat_frame_count}, 64'd5);
    m_axis_tready = 1'b1;
    waitWords(16, 60, "t6_drain");
    idle(3);
    checkOutput("t6_drain_count", 64'(got_q.size()), 64'd16);
    got_q.delete();
    ctrl_enable = 1'b0;
    sendFrame(16'h6500, 8, 1'b0);
    idle(6);
    checkOutput("t6_dis_words", 64'(got_q.size()), 64'd0);
    checkOutput("t6_dis_flags", {62'd0, stat_overflow, stat_seq_error}, 64'd0);
    checkOutput("t6_dis_frames", {32'd0, stat_frame_count}, 64'd5);
    ctrl_enable = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) ctrl_enable = 1'b0;
      applyStimulus(4'(c), 16'h6600 + 16'(c));
    end
    waitWords(4, 20, "t6_midoff");
    idle(3);
    checkOutput("t6_midoff_count", 64'(got_q.size()), 64'd4);
    checkOutput("t6_midoff_last", {31'd0, got_q[3]}, {31'd0, expWord(16'h6600, 3)});
    checkOutput("t6_midoff_frames", {32'd0, stat_frame_count}, 64'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
